// File: rtl/dly_tap_val_ctrl.sv
// dly_tap_val_ctrl: per-channel delay-tap register bank with edge-detected
// LOAD/ADJ commands, saturating steps and registered status pulses.
`default_nettype none

module dly_tap_val_ctrl #(
    parameter int NUM_DLY    = 20,
    parameter int ADDR_W     = 5,
    parameter int TAP_W      = 6,
    parameter int DELAY_INIT = 0,
    parameter int MAX_TAP    = 63
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [ADDR_W-1:0]        DLY_ADDR,
    input  logic                     DLY_LOAD,
    input  logic                     DLY_ADJ,
    input  logic                     DLY_INCDEC,
    output logic [NUM_DLY*TAP_W-1:0] DLY_TAP_VAL_ARRAY,
    output logic                     DLY_UPDATE,
    output logic                     DLY_SAT,
    output logic                     DLY_ADDR_ERR
);

    localparam logic [TAP_W-1:0]  C_INIT = TAP_W'(DELAY_INIT);
    localparam logic [TAP_W-1:0]  C_MAX  = TAP_W'(MAX_TAP);
    localparam logic [ADDR_W:0]   C_NUM  = (ADDR_W+1)'(NUM_DLY);

    logic [TAP_W-1:0] tap_q [NUM_DLY];
    logic [TAP_W-1:0] tap_d [NUM_DLY];
    logic             load_q, load_d;
    logic             adj_q, adj_d;
    logic             update_q, update_d;
    logic             sat_q, sat_d;
    logic             addr_err_q, addr_err_d;

    logic             load_rise;
    logic             adj_rise;
    logic             addr_bad;
    logic             wr_en;
    logic [TAP_W-1:0] sel_tap;
    logic [TAP_W-1:0] new_tap;

    always_comb begin
        tap_d      = tap_q;
        load_d     = DLY_LOAD;
        adj_d      = DLY_ADJ;
        update_d   = 1'b0;
        sat_d      = 1'b0;
        addr_err_d = 1'b0;
        wr_en      = 1'b0;
        new_tap    = '0;
        sel_tap    = '0;

        load_rise = DLY_LOAD & ~load_q;
        adj_rise  = DLY_ADJ  & ~adj_q;
        addr_bad  = ({1'b0, DLY_ADDR} >= C_NUM);

        // Selecting via comparison keeps out-of-range addresses from indexing the bank.
        for (int i = 0; i < NUM_DLY; i++) begin
            if (DLY_ADDR == ADDR_W'(i)) begin
                sel_tap = tap_q[i];
            end
        end

        if (load_rise || adj_rise) begin
            if (addr_bad) begin
                addr_err_d = 1'b1;
            end else if (load_rise) begin
                wr_en    = 1'b1;
                new_tap  = C_INIT;
                update_d = 1'b1;
            end else if (DLY_INCDEC) begin
                if (sel_tap < C_MAX) begin
                    wr_en    = 1'b1;
                    new_tap  = sel_tap + 1'b1;
                    update_d = 1'b1;
                end else begin
                    sat_d = 1'b1;
                end
            end else begin
                if (sel_tap != '0) begin
                    wr_en    = 1'b1;
                    new_tap  = sel_tap - 1'b1;
                    update_d = 1'b1;
                end else begin
                    sat_d = 1'b1;
                end
            end
        end

        for (int i = 0; i < NUM_DLY; i++) begin
            if (wr_en && (DLY_ADDR == ADDR_W'(i))) begin
                tap_d[i] = new_tap;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < NUM_DLY; i++) begin
                tap_q[i] <= C_INIT;
            end
            load_q     <= 1'b0;
            adj_q      <= 1'b0;
            update_q   <= 1'b0;
            sat_q      <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            tap_q      <= tap_d;
            load_q     <= load_d;
            adj_q      <= adj_d;
            update_q   <= update_d;
            sat_q      <= sat_d;
            addr_err_q <= addr_err_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DLY; gi++) begin : g_flat
            assign DLY_TAP_VAL_ARRAY[TAP_W*gi +: TAP_W] = tap_q[gi];
        end
    endgenerate

    assign DLY_UPDATE   = update_q;
    assign DLY_SAT      = sat_q;
    assign DLY_ADDR_ERR = addr_err_q;

endmodule

`default_nettype wire

// File: tb/tb_dly_tap_val_ctrl.sv
// Directed bench for dly_tap_val_ctrl: vector table plus hand sequences for
// saturation, held levels, mid-run reset and a flat-bus mux cross-check.
`default_nettype none

module tb_dly_tap_val_ctrl;

    localparam int NUM_DLY = 20;
    localparam int ADDR_W  = 5;
    localparam int TAP_W   = 6;
    localparam int INIT    = 0;
    localparam int MAXT    = 63;

    logic                     CLK = 1'b0;
    logic                     RST = 1'b0;
    logic [ADDR_W-1:0]        DLY_ADDR = '0;
    logic                     DLY_LOAD = 1'b0;
    logic                     DLY_ADJ = 1'b0;
    logic                     DLY_INCDEC = 1'b0;
    logic [NUM_DLY*TAP_W-1:0] arr;
    logic                     upd, sat, err;

    int total = 0;
    int bad   = 0;
    logic [TAP_W-1:0] model [NUM_DLY];

    dly_tap_val_ctrl #(
        .NUM_DLY(NUM_DLY), .ADDR_W(ADDR_W), .TAP_W(TAP_W),
        .DELAY_INIT(INIT), .MAX_TAP(MAXT)
    ) dut (
        .CLK(CLK), .RST(RST), .DLY_ADDR(DLY_ADDR), .DLY_LOAD(DLY_LOAD),
        .DLY_ADJ(DLY_ADJ), .DLY_INCDEC(DLY_INCDEC), .DLY_TAP_VAL_ARRAY(arr),
        .DLY_UPDATE(upd), .DLY_SAT(sat), .DLY_ADDR_ERR(err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic              load;
        logic              adj;
        logic              incdec;
        logic [TAP_W-1:0]  exp_tap;
        logic              exp_upd;
        logic              exp_sat;
        logic              exp_err;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [NUM_DLY*TAP_W-1:0] model_flat();
        logic [NUM_DLY*TAP_W-1:0] f;
        for (int i = 0; i < NUM_DLY; i++) f[TAP_W*i +: TAP_W] = model[i];
        return f;
    endfunction

    // One ADJ pulse (high one cycle, low one cycle); returns the status seen.
    task automatic adj_pulse(input int a, input logic inc, output logic o_upd, output logic o_sat);
        DLY_ADDR   = ADDR_W'(a);
        DLY_INCDEC = inc;
        DLY_ADJ    = 1'b1;
        @(negedge CLK);
        o_upd = upd;
        o_sat = sat;
        DLY_ADJ = 1'b0;
        @(negedge CLK);
    endtask

    initial begin
        logic u, s;
        int   a, n;
        int   ups;

        vecs[0]  = '{5'd3,  1'b0, 1'b1, 1'b1, 6'd1, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{5'd3,  1'b0, 1'b1, 1'b1, 6'd2, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{5'd3,  1'b0, 1'b1, 1'b1, 6'd3, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{5'd3,  1'b0, 1'b1, 1'b1, 6'd4, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{5'd3,  1'b0, 1'b1, 1'b1, 6'd5, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{5'd7,  1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{5'd21, 1'b0, 1'b1, 1'b1, 6'd0, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{5'd3,  1'b1, 1'b1, 1'b1, 6'd0, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{5'd3,  1'b0, 1'b1, 1'b1, 6'd1, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{5'd19, 1'b1, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{5'd19, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{5'd20, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1};

        for (int i = 0; i < NUM_DLY; i++) model[i] = TAP_W'(INIT);

        repeat (3) @(negedge CLK);
        chk("reset_array", 128'(arr), 128'(model_flat()));
        chk("reset_pulses", 128'({upd, sat, err}), 128'(3'b000));
        RST = 1'b1;
        @(negedge CLK);

        foreach (vecs[v]) begin
            DLY_ADDR   = vecs[v].addr;
            DLY_LOAD   = vecs[v].load;
            DLY_ADJ    = vecs[v].adj;
            DLY_INCDEC = vecs[v].incdec;
            @(negedge CLK);
            if (int'(vecs[v].addr) < NUM_DLY) model[vecs[v].addr] = vecs[v].exp_tap;
            chk($sformatf("vec%0d_status", v), 128'({upd, sat, err}),
                128'({vecs[v].exp_upd, vecs[v].exp_sat, vecs[v].exp_err}));
            chk($sformatf("vec%0d_array", v), 128'(arr), 128'(model_flat()));
            DLY_LOAD = 1'b0;
            DLY_ADJ  = 1'b0;
            @(negedge CLK);
            chk($sformatf("vec%0d_pulse_clear", v), 128'({upd, sat, err}), 128'(3'b000));
        end

        // Walk channel 7 up from 0: 63 accepted steps, the 64th saturates.
        for (int k = 1; k <= 64; k++) begin
            adj_pulse(7, 1'b1, u, s);
            if (k == 63) chk("inc63_update", 128'({u, s}), 128'(2'b10));
            if (k == 64) chk("inc64_sat", 128'({u, s}), 128'(2'b01));
        end
        model[7] = 6'd63;
        chk("tap7_max_array", 128'(arr), 128'(model_flat()));

        // ADJ held high for 10 cycles must step only once.
        ups = 0;
        DLY_ADDR   = 5'd5;
        DLY_INCDEC = 1'b1;
        DLY_ADJ    = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            if (upd) ups++;
        end
        DLY_ADJ = 1'b0;
        @(negedge CLK);
        model[5] = 6'd1;
        chk("held_adj_updates", 128'(ups), 128'(1));
        chk("held_adj_array", 128'(arr), 128'(model_flat()));

        // Asynchronous reset while a command is in flight.
        DLY_ADDR = 5'd3;
        DLY_ADJ  = 1'b1;
        #2 RST = 1'b0;
        #1;
        for (int i = 0; i < NUM_DLY; i++) model[i] = TAP_W'(INIT);
        chk("midreset_array", 128'(arr), 128'(model_flat()));
        chk("midreset_pulses", 128'({upd, sat, err}), 128'(3'b000));
        @(negedge CLK);
        DLY_ADJ = 1'b0;
        RST     = 1'b1;
        @(negedge CLK);
        chk("post_reset_array", 128'(arr), 128'(model_flat()));

        // Random channel/tap sweep checked through a downstream-style mux on the flat bus.
        for (int r = 0; r < 8; r++) begin
            a = $urandom_range(0, NUM_DLY-1);
            n = $urandom_range(1, 8);
            for (int k = 0; k < n; k++) begin
                adj_pulse(a, 1'b1, u, s);
                if (model[a] < 6'd63) model[a] = model[a] + 6'd1;
            end
            DLY_ADDR = ADDR_W'(a);
            #1;
            chk($sformatf("mux_ch%0d", a), 128'(arr[TAP_W*a +: TAP_W]), 128'(model[a]));
        end
        chk("sweep_array", 128'(arr), 128'(model_flat()));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
